// File: rtl/dfr_phase_sequencer_if.sv
// ----------------------------------------------------------------------------
// dfr_phase_sequencer_if
// Bundles the datapath-facing signals of the DFR phase sequencer.
//   master (sequencer side): drives input-mem read, reservoir request,
//                            history write, matmul launch and output write;
//                            receives res_ack and mm_done.
//   slave  (datapath side) : the mirror image.
// Signals:
//   in_rd_en / in_rd_addr      input mem read strobe / global step index
//   res_req / res_ack          reservoir step handshake
//   hist_wr_en / hist_wr_addr  reservoir history write strobe / address
//   mm_start / mm_base_addr    matmul launch / first history addr of the sample
//   mm_done                    matmul result valid
//   out_wr_en / out_wr_addr    DFR output write strobe / test sample index
// ----------------------------------------------------------------------------
interface dfr_phase_sequencer_if #(
    parameter int IN_ADDR_WIDTH   = 16,
    parameter int HIST_ADDR_WIDTH = 16,
    parameter int OUT_ADDR_WIDTH  = 16
);
    logic                       in_rd_en;
    logic [IN_ADDR_WIDTH-1:0]   in_rd_addr;
    logic                       res_req;
    logic                       res_ack;
    logic                       hist_wr_en;
    logic [HIST_ADDR_WIDTH-1:0] hist_wr_addr;
    logic                       mm_start;
    logic [HIST_ADDR_WIDTH-1:0] mm_base_addr;
    logic                       mm_done;
    logic                       out_wr_en;
    logic [OUT_ADDR_WIDTH-1:0]  out_wr_addr;

    modport master (
        output in_rd_en, in_rd_addr, res_req, hist_wr_en, hist_wr_addr,
               mm_start, mm_base_addr, out_wr_en, out_wr_addr,
        input  res_ack, mm_done
    );

    modport slave (
        input  in_rd_en, in_rd_addr, res_req, hist_wr_en, hist_wr_addr,
               mm_start, mm_base_addr, out_wr_en, out_wr_addr,
        output res_ack, mm_done
    );
endinterface

// File: rtl/dfr_phase_sequencer.sv
// ----------------------------------------------------------------------------
// dfr_phase_sequencer
// Walks the DFR datapath through the INIT, TRAIN and TEST phases after a
// start pulse. Every step reads one input sample, handshakes one reservoir
// step and (outside INIT) logs the reservoir output to history memory. After
// each TEST sample the output matmul is launched and its result committed to
// the DFR output memory.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             launch pulse, ignored while busy
//   cfg_*_samples     per-phase sample counts (latched on start)
//   cfg_steps         reservoir steps per sample (latched on start)
//   busy/done/cfg_err run status; done and cfg_err are 1-cycle pulses
//   phase             0 idle, 1 init, 2 train, 3 test
//   bus               datapath handshakes (dfr_phase_sequencer_if.master)
// ----------------------------------------------------------------------------
module dfr_phase_sequencer #(
    parameter int CFG_WIDTH       = 32,
    parameter int IN_ADDR_WIDTH   = 16,
    parameter int HIST_ADDR_WIDTH = 16,
    parameter int OUT_ADDR_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CFG_WIDTH-1:0] cfg_init_samples,
    input  logic [CFG_WIDTH-1:0] cfg_train_samples,
    input  logic [CFG_WIDTH-1:0] cfg_test_samples,
    input  logic [CFG_WIDTH-1:0] cfg_steps,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err,
    output logic [1:0]           phase,
    dfr_phase_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_REQ, S_MM_START, S_MM_WAIT, S_DONE
    } state_t;

    localparam logic [1:0] PH_NONE  = 2'd0;
    localparam logic [1:0] PH_INIT  = 2'd1;
    localparam logic [1:0] PH_TRAIN = 2'd2;
    localparam logic [1:0] PH_TEST  = 2'd3;

    localparam logic [CFG_WIDTH-1:0]       CFG_ONE  = 1;
    localparam logic [IN_ADDR_WIDTH-1:0]   IN_ONE   = 1;
    localparam logic [HIST_ADDR_WIDTH-1:0] HIST_ONE = 1;
    localparam logic [OUT_ADDR_WIDTH-1:0]  OUT_ONE  = 1;

    state_t                     state_q, state_d;
    logic [1:0]                 cur_phase_q, cur_phase_d;
    logic [CFG_WIDTH-1:0]       init_n_q, init_n_d;
    logic [CFG_WIDTH-1:0]       train_n_q, train_n_d;
    logic [CFG_WIDTH-1:0]       test_n_q, test_n_d;
    logic [CFG_WIDTH-1:0]       steps_q, steps_d;
    logic [CFG_WIDTH-1:0]       step_q, step_d;       // step within sample
    logic [CFG_WIDTH-1:0]       sample_q, sample_d;   // sample within phase
    logic [IN_ADDR_WIDTH-1:0]   gstep_q, gstep_d;     // global step index
    logic [HIST_ADDR_WIDTH-1:0] hist_addr_q, hist_addr_d;
    logic [HIST_ADDR_WIDTH-1:0] base_q, base_d;       // first hist addr of sample
    logic [OUT_ADDR_WIDTH-1:0]  out_addr_q, out_addr_d;

    // Registered outputs, loaded from the next-state decode
    logic       in_rd_en_q, res_req_q, mm_start_q;
    logic       busy_q, done_q, cfg_err_q;
    logic [1:0] phase_q;

    logic                 step_hs;
    logic                 hist_wr;
    logic                 out_wr;
    logic [CFG_WIDTH-1:0] cur_count;
    logic [1:0]           first_phase;
    logic [1:0]           next_phase;

    // res_req_q is high exactly in REQ, so this is the completed handshake
    assign step_hs = res_req_q & bus.res_ack;
    assign hist_wr = step_hs & (cur_phase_q != PH_INIT);
    assign out_wr  = (state_q == S_MM_WAIT) & bus.mm_done;

    always_comb begin
        // Phases with zero samples are skipped on launch and on advance
        first_phase = PH_NONE;
        if (cfg_init_samples != '0)       first_phase = PH_INIT;
        else if (cfg_train_samples != '0) first_phase = PH_TRAIN;
        else if (cfg_test_samples != '0)  first_phase = PH_TEST;

        next_phase = PH_NONE;
        if (cur_phase_q == PH_INIT && train_n_q != '0) next_phase = PH_TRAIN;
        else if (cur_phase_q != PH_TEST && test_n_q != '0) next_phase = PH_TEST;

        case (cur_phase_q)
            PH_INIT:  cur_count = init_n_q;
            PH_TRAIN: cur_count = train_n_q;
            default:  cur_count = test_n_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cur_phase_d = cur_phase_q;
        init_n_d    = init_n_q;
        train_n_d   = train_n_q;
        test_n_d    = test_n_q;
        steps_d     = steps_q;
        step_d      = step_q;
        sample_d    = sample_q;
        gstep_d     = gstep_q;
        hist_addr_d = hist_addr_q;
        base_d      = base_q;
        out_addr_d  = out_addr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    init_n_d    = cfg_init_samples;
                    train_n_d   = cfg_train_samples;
                    test_n_d    = cfg_test_samples;
                    steps_d     = cfg_steps;
                    step_d      = '0;
                    sample_d    = '0;
                    gstep_d     = '0;
                    hist_addr_d = '0;
                    base_d      = '0;
                    out_addr_d  = '0;
                    if (cfg_steps == '0 || first_phase == PH_NONE) begin
                        state_d = S_DONE;
                    end else begin
                        state_d     = S_RD;
                        cur_phase_d = first_phase;
                    end
                end
            end
            S_RD: state_d = S_REQ;
            S_REQ: begin
                if (step_hs) begin
                    gstep_d = gstep_q + IN_ONE;
                    if (hist_wr) hist_addr_d = hist_addr_q + HIST_ONE;
                    if (step_q == steps_q - CFG_ONE) begin
                        step_d = '0;
                        if (cur_phase_q == PH_TEST) begin
                            // base_q still points at this sample's first step
                            state_d = S_MM_START;
                        end else begin
                            base_d = hist_addr_d;
                            if (sample_q == cur_count - CFG_ONE) begin
                                sample_d = '0;
                                if (next_phase == PH_NONE) begin
                                    state_d = S_DONE;
                                end else begin
                                    cur_phase_d = next_phase;
                                    state_d     = S_RD;
                                end
                            end else begin
                                sample_d = sample_q + CFG_ONE;
                                state_d  = S_RD;
                            end
                        end
                    end else begin
                        step_d  = step_q + CFG_ONE;
                        state_d = S_RD;
                    end
                end
            end
            S_MM_START: state_d = S_MM_WAIT;
            S_MM_WAIT: begin
                if (bus.mm_done) begin
                    out_addr_d = out_addr_q + OUT_ONE;
                    base_d     = hist_addr_q;
                    if (sample_q == test_n_q - CFG_ONE) begin
                        state_d = S_DONE;
                    end else begin
                        sample_d = sample_q + CFG_ONE;
                        state_d  = S_RD;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_phase_q <= PH_NONE;
            init_n_q    <= '0;
            train_n_q   <= '0;
            test_n_q    <= '0;
            steps_q     <= '0;
            step_q      <= '0;
            sample_q    <= '0;
            gstep_q     <= '0;
            hist_addr_q <= '0;
            base_q      <= '0;
            out_addr_q  <= '0;
            in_rd_en_q  <= 1'b0;
            res_req_q   <= 1'b0;
            mm_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            phase_q     <= PH_NONE;
        end else begin
            state_q     <= state_d;
            cur_phase_q <= cur_phase_d;
            init_n_q    <= init_n_d;
            train_n_q   <= train_n_d;
            test_n_q    <= test_n_d;
            steps_q     <= steps_d;
            step_q      <= step_d;
            sample_q    <= sample_d;
            gstep_q     <= gstep_d;
            hist_addr_q <= hist_addr_d;
            base_q      <= base_d;
            out_addr_q  <= out_addr_d;
            in_rd_en_q  <= (state_d == S_RD);
            res_req_q   <= (state_d == S_REQ);
            mm_start_q  <= (state_d == S_MM_START);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
            // DONE straight from IDLE is the only path that can carry an error
            cfg_err_q   <= (state_q == S_IDLE) && start && (cfg_steps == '0);
            phase_q     <= (state_d == S_IDLE || state_d == S_DONE) ? PH_NONE : cur_phase_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign cfg_err          = cfg_err_q;
    assign phase            = phase_q;
    assign bus.in_rd_en     = in_rd_en_q;
    assign bus.in_rd_addr   = gstep_q;
    assign bus.res_req      = res_req_q;
    assign bus.hist_wr_en   = hist_wr;
    assign bus.hist_wr_addr = hist_addr_q;
    assign bus.mm_start     = mm_start_q;
    assign bus.mm_base_addr = base_q;
    assign bus.out_wr_en    = out_wr;
    assign bus.out_wr_addr  = out_addr_q;
endmodule

// File: tb/tb_dfr_phase_sequencer.sv
// ----------------------------------------------------------------------------
// tb_dfr_phase_sequencer
// Drives runs of the phase sequencer with directed and $urandom configurations
// and handshake timing. An event-list reference model expands each
// configuration into the expected reads, history writes, matmul bases and
// output writes; a monitor matches DUT strobes against those lists.
// ----------------------------------------------------------------------------
module tb_dfr_phase_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] cfg_init_samples = '0;
    logic [31:0] cfg_train_samples = '0;
    logic [31:0] cfg_test_samples = '0;
    logic [31:0] cfg_steps = '0;
    logic        busy, done, cfg_err;
    logic [1:0]  phase;

    dfr_phase_sequencer_if bus ();

    dfr_phase_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .cfg_init_samples  (cfg_init_samples),
        .cfg_train_samples (cfg_train_samples),
        .cfg_test_samples  (cfg_test_samples),
        .cfg_steps         (cfg_steps),
        .busy              (busy),
        .done              (done),
        .cfg_err           (cfg_err),
        .phase             (phase),
        .bus               (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    // Expected event lists; read entries carry {phase, addr}
    int exp_rd[$];
    int exp_hist[$];
    int exp_mm[$];
    int exp_out[$];

    // Handshake timing: -2 tied high, -1 random, >=0 fixed delay in cycles
    int ack_delay = -2;
    int mm_delay  = -2;
    int req_wait  = 0;
    int mm_wait   = 0;
    bit prev_out_wr = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Expand a configuration into the ordered events the run must produce
    task automatic build_model(input int ni, input int nt, input int nx, input int ns);
        int g, h, o, n, base;
        exp_rd.delete(); exp_hist.delete(); exp_mm.delete(); exp_out.delete();
        if (ns == 0 || (ni + nt + nx) == 0) return;
        g = 0; h = 0; o = 0;
        for (int p = 1; p <= 3; p++) begin
            n = (p == 1) ? ni : (p == 2) ? nt : nx;
            for (int s = 0; s < n; s++) begin
                base = h;
                for (int k = 0; k < ns; k++) begin
                    exp_rd.push_back((p << 16) | (g & 16'hFFFF));
                    g++;
                    if (p != 1) begin
                        exp_hist.push_back(h & 16'hFFFF);
                        h++;
                    end
                end
                if (p == 3) begin
                    exp_mm.push_back(base & 16'hFFFF);
                    exp_out.push_back(o & 16'hFFFF);
                    o++;
                end
            end
        end
    endtask

    // Datapath responder, driven just after each rising edge
    always @(posedge clk) begin
        #1;
        if (bus.res_req) req_wait++; else req_wait = 0;
        if (bus.mm_start) mm_wait = 0; else mm_wait++;
        if (ack_delay == -2)      bus.res_ack = 1'b1;
        else if (ack_delay == -1) bus.res_ack = 1'($urandom_range(0, 1));
        else                      bus.res_ack = bus.res_req && (req_wait > ack_delay);
        if (mm_delay == -2)       bus.mm_done = 1'b1;
        else if (mm_delay == -1)  bus.mm_done = 1'($urandom_range(0, 1));
        else                      bus.mm_done = (mm_wait >= mm_delay);
    end

    // Monitor: every strobe must match the head of its expected list
    always @(negedge clk) begin
        int e;
        if (!rst) begin
            if (prev_out_wr && exp_rd.size() > 0)
                check_eq("rd_after_mm", bus.in_rd_en, 1);
            prev_out_wr = bus.out_wr_en;
            if (bus.in_rd_en) begin
                if (exp_rd.size() > 0) begin
                    e = exp_rd.pop_front();
                    check_eq("rd_addr", bus.in_rd_addr, e & 16'hFFFF);
                    check_eq("rd_phase", phase, e >> 16);
                end else check_eq("rd_unexpected", exp_rd.size(), 1);
            end
            if (bus.hist_wr_en) begin
                check_eq("hist_hs", bus.res_req & bus.res_ack, 1);
                if (exp_hist.size() > 0) check_eq("hist_addr", bus.hist_wr_addr, exp_hist.pop_front());
                else check_eq("hist_unexpected", exp_hist.size(), 1);
            end
            if (bus.mm_start) begin
                if (exp_mm.size() > 0) check_eq("mm_base", bus.mm_base_addr, exp_mm.pop_front());
                else check_eq("mm_unexpected", exp_mm.size(), 1);
            end
            if (bus.out_wr_en) begin
                check_eq("out_on_mm_done", bus.mm_done, 1);
                if (exp_out.size() > 0) check_eq("out_addr", bus.out_wr_addr, exp_out.pop_front());
                else check_eq("out_unexpected", exp_out.size(), 1);
            end
            if (done) begin
                done_cnt++;
                check_eq("busy_in_done", busy, 1);
            end
            if (cfg_err) begin
                err_cnt++;
                check_eq("err_with_done", done, 1);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_cfg_err"}, cfg_err, 0);
        check_eq({tag, "_phase"}, phase, 0);
        check_eq({tag, "_in_rd_en"}, bus.in_rd_en, 0);
        check_eq({tag, "_in_rd_addr"}, bus.in_rd_addr, 0);
        check_eq({tag, "_res_req"}, bus.res_req, 0);
        check_eq({tag, "_hist_wr_en"}, bus.hist_wr_en, 0);
        check_eq({tag, "_hist_wr_addr"}, bus.hist_wr_addr, 0);
        check_eq({tag, "_mm_start"}, bus.mm_start, 0);
        check_eq({tag, "_mm_base"}, bus.mm_base_addr, 0);
        check_eq({tag, "_out_wr_en"}, bus.out_wr_en, 0);
        check_eq({tag, "_out_wr_addr"}, bus.out_wr_addr, 0);
    endtask

    task automatic launch(input int ni, input int nt, input int nx, input int ns);
        @(negedge clk);
        cfg_init_samples  = ni;
        cfg_train_samples = nt;
        cfg_test_samples  = nx;
        cfg_steps         = ns;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);
        // Scramble the config inputs: the run must use the latched copy
        cfg_init_samples  = $urandom;
        cfg_train_samples = $urandom;
        cfg_test_samples  = $urandom;
        cfg_steps         = $urandom;
    endtask

    task automatic run_case(input int ni, input int nt, input int nx, input int ns,
                            input int ad, input int md, input bit mid_start);
        int cyc;
        build_model(ni, nt, nx, ns);
        ack_delay = ad;
        mm_delay  = md;
        done_cnt  = 0;
        err_cnt   = 0;
        launch(ni, nt, nx, ns);
        cyc = 0;
        while (done_cnt == 0 && cyc < 20000) begin
            start = (mid_start && cyc == 30);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("done_pulses", done_cnt, 1);
        check_eq("cfg_err_pulses", err_cnt, (ns == 0) ? 1 : 0);
        check_eq("busy_idle", busy, 0);
        check_eq("rd_left", exp_rd.size(), 0);
        check_eq("hist_left", exp_hist.size(), 0);
        check_eq("mm_left", exp_mm.size(), 0);
        check_eq("out_left", exp_out.size(), 0);
        $display("run init=%0d train=%0d test=%0d steps=%0d ack=%0d mm=%0d cycles=%0d",
                 ni, nt, nx, ns, ad, md, cyc);
    endtask

    initial begin
        int cyc;
        bus.res_ack = 1'b0;
        bus.mm_done = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // T1: test-only, tied handshakes
        run_case(0, 0, 5, 10, -2, -2, 1'b0);
        // T2: all three phases, random handshakes
        run_case(2, 3, 1, 4, -1, -1, 1'b0);
        // T3: slow reservoir, start pulsed mid-run
        run_case(1, 2, 2, 3, 5, 0, 1'b1);
        // T4: bad step count, then empty run
        run_case(1, 1, 1, 0, -2, -2, 1'b0);
        run_case(0, 0, 0, 7, -2, -2, 1'b0);

        // T5: reset in the middle of TEST aborts without a done pulse
        build_model(0, 0, 5, 10);
        ack_delay = -2;
        mm_delay  = -2;
        done_cnt  = 0;
        launch(0, 0, 5, 10);
        cyc = 0;
        while (phase != 2'd3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("t5_in_test", phase, 3);
        repeat (23) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        exp_rd.delete(); exp_hist.delete(); exp_mm.delete(); exp_out.delete();
        done_cnt = 0;
        repeat (10) @(negedge clk);
        check_eq("abort_no_done", done_cnt, 0);
        check_eq("abort_idle", busy, 0);
        $display("run reset abort mid-test");
        run_case(0, 0, 5, 10, -2, -2, 1'b0);

        // T6: late matmul result
        run_case(0, 0, 2, 3, 0, 20, 1'b0);

        // Random configurations and handshake timing
        for (int i = 0; i < 8; i++) begin
            run_case($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4),
                     -1, $urandom_range(0, 1) ? -1 : int'($urandom_range(0, 3)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
